// File: rtl/pll_adc_supervisor_if.sv
// Signal bundle between the PLL/ADC supervisor and its environment.
// The slave side is the supervisor; the master side is the environment that drives the lock indicator and restart.
interface pll_adc_supervisor_if;
    logic       pll_locked;
    logic       restart;
    logic       pll_rst;
    logic       adc_en;
    logic       fail;
    logic [2:0] state;
    logic [1:0] retry_cnt;
    logic [7:0] lock_loss_cnt;

    modport master (
        output pll_locked, restart,
        input  pll_rst, adc_en, fail, state, retry_cnt, lock_loss_cnt
    );

    modport slave (
        input  pll_locked, restart,
        output pll_rst, adc_en, fail, state, retry_cnt, lock_loss_cnt
    );
endinterface

// File: rtl/pll_adc_supervisor.sv
// PLL reset/lock supervisor gating ADC capture: HOLD -> WAIT_LOCK -> SETTLE -> RUN, with retries and FAIL.
// Define PLL_ADC_SUP_LOSS_CNT_EN to build the saturating lock-loss event counter; otherwise lock_loss_cnt is tied to 0.
module pll_adc_supervisor #(
    parameter int RST_HOLD_CYCLES = 16,
    parameter int LOCK_TIMEOUT    = 65535,
    parameter int LOCK_STABLE     = 1024,
    parameter int MAX_RETRIES     = 3
) (
    input  logic                 refclk,
    input  logic                 rst,
    pll_adc_supervisor_if.slave  sup
);

    typedef enum logic [2:0] {
        ST_HOLD   = 3'd0,
        ST_WAIT   = 3'd1,
        ST_SETTLE = 3'd2,
        ST_RUN    = 3'd3,
        ST_FAIL   = 3'd4
    } state_e;

    localparam logic [7:0]  HOLD_LAST = 8'(RST_HOLD_CYCLES - 1);
    localparam logic [15:0] TMO_LAST  = 16'(LOCK_TIMEOUT - 1);
    localparam logic [15:0] STB_LAST  = 16'(LOCK_STABLE - 1);
    localparam logic [1:0]  MAX_R     = 2'(MAX_RETRIES);

    logic        sync1, locked_s;
    state_e      state_q, state_nxt;
    logic [1:0]  retry_q, retry_nxt;
    logic [7:0]  hold_cnt, hold_nxt;
    logic [15:0] tmr, tmr_nxt;
    logic [15:0] stab, stab_nxt;
    logic        pll_rst_q, adc_en_q, fail_q;

    // pll_locked is asynchronous; nothing downstream looks at it before the second flop.
    always_ff @(posedge refclk) begin
        if (rst) begin
            sync1    <= 1'b0;
            locked_s <= 1'b0;
        end else begin
            sync1    <= sup.pll_locked;
            locked_s <= sync1;
        end
    end

    always_comb begin
        state_nxt = state_q;
        retry_nxt = retry_q;
        hold_nxt  = hold_cnt;
        tmr_nxt   = tmr;
        stab_nxt  = stab;
        case (state_q)
            ST_HOLD: begin
                if (hold_cnt == HOLD_LAST) state_nxt = ST_WAIT;
                else                       hold_nxt  = hold_cnt + 8'd1;
            end
            ST_WAIT: begin
                if (locked_s) begin
                    state_nxt = ST_SETTLE;
                end else if (tmr == TMO_LAST) begin
                    if (retry_q < MAX_R) begin
                        retry_nxt = retry_q + 2'd1;
                        state_nxt = ST_HOLD;
                    end else begin
                        state_nxt = ST_FAIL;
                    end
                end else begin
                    tmr_nxt = tmr + 16'd1;
                end
            end
            ST_SETTLE: begin
                if (!locked_s)             state_nxt = ST_WAIT;
                else if (stab == STB_LAST) state_nxt = ST_RUN;
                else                       stab_nxt  = stab + 16'd1;
            end
            ST_RUN: begin
                if (!locked_s) state_nxt = ST_HOLD;
            end
            ST_FAIL: ;
            default: state_nxt = ST_HOLD;
        endcase

        if (state_nxt == ST_RUN) retry_nxt = 2'd0;

        if (sup.restart) begin
            state_nxt = ST_HOLD;
            retry_nxt = 2'd0;
        end

        // Any state entry, including a restart re-entering HOLD, starts every counter from zero.
        if (sup.restart || (state_nxt != state_q)) begin
            hold_nxt = 8'd0;
            tmr_nxt  = 16'd0;
            stab_nxt = 16'd0;
        end
    end

    // Outputs are registered from the next state so they line up with the state code.
    always_ff @(posedge refclk) begin
        if (rst) begin
            state_q   <= ST_HOLD;
            retry_q   <= 2'd0;
            hold_cnt  <= 8'd0;
            tmr       <= 16'd0;
            stab      <= 16'd0;
            pll_rst_q <= 1'b1;
            adc_en_q  <= 1'b0;
            fail_q    <= 1'b0;
        end else begin
            state_q   <= state_nxt;
            retry_q   <= retry_nxt;
            hold_cnt  <= hold_nxt;
            tmr       <= tmr_nxt;
            stab      <= stab_nxt;
            pll_rst_q <= (state_nxt == ST_HOLD) || (state_nxt == ST_FAIL);
            adc_en_q  <= (state_nxt == ST_RUN);
            fail_q    <= (state_nxt == ST_FAIL);
        end
    end

    assign sup.state     = state_q;
    assign sup.retry_cnt = retry_q;
    assign sup.pll_rst   = pll_rst_q;
    assign sup.adc_en    = adc_en_q;
    assign sup.fail      = fail_q;

`ifdef PLL_ADC_SUP_LOSS_CNT_EN
    logic       loss_evt;
    logic [7:0] loss_q;

    // Counted even when restart coincides with the loss, since restart only overrides the transition.
    assign loss_evt = (state_q == ST_RUN) && !locked_s;

    always_ff @(posedge refclk) begin
        if (rst)                            loss_q <= 8'd0;
        else if (loss_evt && loss_q != 8'hFF) loss_q <= loss_q + 8'd1;
    end

    assign sup.lock_loss_cnt = loss_q;
`else
    assign sup.lock_loss_cnt = 8'd0;
`endif

endmodule
